// File: rtl/bsg_axil_pkg.sv
// Shared definitions for the AXI-Lite FIFO client: response codes and FSM states.
package bsg_axil_pkg;

  typedef enum logic [1:0] {
    e_axi_resp_okay   = 2'b00,
    e_axi_resp_exokay = 2'b01,
    e_axi_resp_slverr = 2'b10,
    e_axi_resp_decerr = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    e_idle,
    e_req,
    e_wait,
    e_bresp,
    e_rresp
  } fifo_client_state_e;

endpackage

// File: rtl/bsg_axil_fifo_client_buffer.sv
// One-entry valid/ready holding register; the consumer frees it with yumi_i.
module bsg_axil_fifo_client_buffer #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  logic               full_r;
  logic [width_p-1:0] data_r;

  // Never advertise space while reset is held, so nothing is accepted during reset.
  assign ready_o = ~full_r & ~reset_i;
  assign v_o     = full_r;
  assign data_o  = data_r;

  // Capture on handshake; yumi only happens while full, so it never collides with a capture.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      full_r <= 1'b0;
      data_r <= '0;
    end else if (yumi_i) begin
      full_r <= 1'b0;
    end else if (v_i & ready_o) begin
      full_r <= 1'b1;
      data_r <= data_i;
    end
  end

endmodule

// File: rtl/bsg_axil_fifo_client.sv
// AXI4-Lite subordinate that turns each write/read into one valid/ready client
// request, waits for the client response and returns it as B or R.
// data_width_p must be 32 or 64. Address and prot are not decoded.
module bsg_axil_fifo_client
  import bsg_axil_pkg::*;
#(
  parameter  int addr_width_p  = 32,
  parameter  int data_width_p  = 32,
  localparam int strb_width_lp = data_width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic [addr_width_p-1:0]  s_axil_awaddr_i,
  input  logic [2:0]               s_axil_awprot_i,
  input  logic                     s_axil_awvalid_i,
  output logic                     s_axil_awready_o,

  input  logic [data_width_p-1:0]  s_axil_wdata_i,
  input  logic [strb_width_lp-1:0] s_axil_wstrb_i,
  input  logic                     s_axil_wvalid_i,
  output logic                     s_axil_wready_o,

  output logic [1:0]               s_axil_bresp_o,
  output logic                     s_axil_bvalid_o,
  input  logic                     s_axil_bready_i,

  input  logic [addr_width_p-1:0]  s_axil_araddr_i,
  input  logic [2:0]               s_axil_arprot_i,
  input  logic                     s_axil_arvalid_i,
  output logic                     s_axil_arready_o,

  output logic [data_width_p-1:0]  s_axil_rdata_o,
  output logic [1:0]               s_axil_rresp_o,
  output logic                     s_axil_rvalid_o,
  input  logic                     s_axil_rready_i,

  output logic [addr_width_p-1:0]  addr_o,
  output logic [data_width_p-1:0]  data_o,
  output logic [strb_width_lp-1:0] wmask_o,
  output logic                     w_o,
  output logic                     v_o,
  input  logic                     ready_and_i,

  input  logic [data_width_p-1:0]  data_i,
  input  logic                     v_i,
  output logic                     ready_and_o
);

  fifo_client_state_e state_r;
  logic               last_write_r;
  logic               req_w_r;
  logic [addr_width_p-1:0]  req_addr_r;
  logic [data_width_p-1:0]  req_data_r;
  logic [strb_width_lp-1:0] req_mask_r;
  logic [data_width_p-1:0]  rdata_r;

  logic                     aw_v, w_v, ar_v;
  logic [addr_width_p-1:0]  aw_addr, ar_addr;
  logic [data_width_p-1:0]  w_data;
  logic [strb_width_lp-1:0] w_strb;
  logic                     in_idle, write_rdy, read_rdy, grant_write, grant_read;

  // Prot bits carry no meaning for this client.
  logic unused_prot;
  assign unused_prot = ^{s_axil_awprot_i, s_axil_arprot_i};

  bsg_axil_fifo_client_buffer #(.width_p(addr_width_p)) aw_buf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (s_axil_awaddr_i),
    .v_i     (s_axil_awvalid_i),
    .ready_o (s_axil_awready_o),
    .data_o  (aw_addr),
    .v_o     (aw_v),
    .yumi_i  (grant_write)
  );

  bsg_axil_fifo_client_buffer #(.width_p(data_width_p + strb_width_lp)) w_buf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  ({s_axil_wdata_i, s_axil_wstrb_i}),
    .v_i     (s_axil_wvalid_i),
    .ready_o (s_axil_wready_o),
    .data_o  ({w_data, w_strb}),
    .v_o     (w_v),
    .yumi_i  (grant_write)
  );

  bsg_axil_fifo_client_buffer #(.width_p(addr_width_p)) ar_buf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (s_axil_araddr_i),
    .v_i     (s_axil_arvalid_i),
    .ready_o (s_axil_arready_o),
    .data_o  (ar_addr),
    .v_o     (ar_v),
    .yumi_i  (grant_read)
  );

  // A write needs both AW and W; when a write and read are both ready, alternate.
  assign in_idle     = (state_r == e_idle);
  assign write_rdy   = aw_v & w_v;
  assign read_rdy    = ar_v;
  assign grant_write = in_idle & write_rdy & (~read_rdy | ~last_write_r);
  assign grant_read  = in_idle & read_rdy  & (~write_rdy | last_write_r);

  // Transaction sequencer: grant, present request, await response, return B/R.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= e_idle;
      last_write_r <= 1'b0;
      req_w_r      <= 1'b0;
      req_addr_r   <= '0;
      req_data_r   <= '0;
      req_mask_r   <= '0;
      rdata_r      <= '0;
    end else begin
      case (state_r)
        e_idle: begin
          if (grant_write) begin
            req_w_r      <= 1'b1;
            req_addr_r   <= aw_addr;
            req_data_r   <= w_data;
            req_mask_r   <= w_strb;
            last_write_r <= 1'b1;
            state_r      <= e_req;
          end else if (grant_read) begin
            req_w_r      <= 1'b0;
            req_addr_r   <= ar_addr;
            req_data_r   <= '0;
            req_mask_r   <= '0;
            last_write_r <= 1'b0;
            state_r      <= e_req;
          end
        end
        e_req: begin
          if (ready_and_i) state_r <= e_wait;
        end
        e_wait: begin
          if (v_i) begin
            if (req_w_r) begin
              state_r <= e_bresp;
            end else begin
              rdata_r <= data_i;
              state_r <= e_rresp;
            end
          end
        end
        e_bresp: begin
          if (s_axil_bready_i) state_r <= e_idle;
        end
        e_rresp: begin
          if (s_axil_rready_i) state_r <= e_idle;
        end
        default: state_r <= e_idle;
      endcase
    end
  end

  // Handshake outputs come straight from the state register, forced low while reset is held.
  assign v_o             = (state_r == e_req)   & ~reset_i;
  assign ready_and_o     = (state_r == e_wait)  & ~reset_i;
  assign s_axil_bvalid_o = (state_r == e_bresp) & ~reset_i;
  assign s_axil_rvalid_o = (state_r == e_rresp) & ~reset_i;

  assign w_o     = req_w_r;
  assign addr_o  = req_addr_r;
  assign data_o  = req_data_r;
  assign wmask_o = req_mask_r;

  assign s_axil_rdata_o = rdata_r;
  assign s_axil_bresp_o = e_axi_resp_okay;
  assign s_axil_rresp_o = e_axi_resp_okay;

endmodule

// File: tb/tb_bsg_axil_fifo_client.sv
// Self-checking bench for bsg_axil_fifo_client: directed scenarios plus a
// randomized sequence checked against a byte-masked memory model.
module tb_bsg_axil_fifo_client;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [AW-1:0] s_axil_awaddr_i, s_axil_araddr_i;
  logic [2:0]    s_axil_awprot_i, s_axil_arprot_i;
  logic          s_axil_awvalid_i, s_axil_awready_o;
  logic [DW-1:0] s_axil_wdata_i;
  logic [SW-1:0] s_axil_wstrb_i;
  logic          s_axil_wvalid_i, s_axil_wready_o;
  logic [1:0]    s_axil_bresp_o, s_axil_rresp_o;
  logic          s_axil_bvalid_o, s_axil_bready_i;
  logic          s_axil_arvalid_i, s_axil_arready_o;
  logic [DW-1:0] s_axil_rdata_o;
  logic          s_axil_rvalid_o, s_axil_rready_i;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] data_o, data_i;
  logic [SW-1:0] wmask_o;
  logic          w_o, v_o, ready_and_i, v_i, ready_and_o;

  bsg_axil_fifo_client #(.addr_width_p(AW), .data_width_p(DW)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .s_axil_awaddr_i(s_axil_awaddr_i), .s_axil_awprot_i(s_axil_awprot_i),
    .s_axil_awvalid_i(s_axil_awvalid_i), .s_axil_awready_o(s_axil_awready_o),
    .s_axil_wdata_i(s_axil_wdata_i), .s_axil_wstrb_i(s_axil_wstrb_i),
    .s_axil_wvalid_i(s_axil_wvalid_i), .s_axil_wready_o(s_axil_wready_o),
    .s_axil_bresp_o(s_axil_bresp_o), .s_axil_bvalid_o(s_axil_bvalid_o),
    .s_axil_bready_i(s_axil_bready_i),
    .s_axil_araddr_i(s_axil_araddr_i), .s_axil_arprot_i(s_axil_arprot_i),
    .s_axil_arvalid_i(s_axil_arvalid_i), .s_axil_arready_o(s_axil_arready_o),
    .s_axil_rdata_o(s_axil_rdata_o), .s_axil_rresp_o(s_axil_rresp_o),
    .s_axil_rvalid_o(s_axil_rvalid_o), .s_axil_rready_i(s_axil_rready_i),
    .addr_o(addr_o), .data_o(data_o), .wmask_o(wmask_o), .w_o(w_o), .v_o(v_o),
    .ready_and_i(ready_and_i), .data_i(data_i), .v_i(v_i), .ready_and_o(ready_and_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] m;
    int            seen;
    int            acc;
  } req_t;

  req_t log_q[$];
  logic [DW-1:0] cmem [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  int cfg_stall = 0;
  int cfg_delay = 0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] cmem_rd(input logic [AW-1:0] a);
    return cmem.exists(a) ? cmem[a] : '0;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  // Client memory model: stalls ready_and_i, logs every accepted request, answers after cfg_delay.
  bit            c_seen = 0, c_pend = 0, c_pend_w = 0;
  int            c_scnt = 0, c_dcnt = 0, c_unstable = 0;
  logic [AW-1:0] c_pend_a;
  req_t          c_cur;
  always @(negedge clk) begin
    if (reset_i) begin
      ready_and_i = 1'b0;
      v_i         = 1'b0;
      c_pend      = 0;
      c_seen      = 0;
    end else begin
      v_i    = 1'b0;
      data_i = $urandom;
      if (c_pend) begin
        if (c_dcnt >= cfg_delay) begin
          v_i = 1'b1;
          if (!c_pend_w) data_i = cmem_rd(c_pend_a);
          if (ready_and_o) c_pend = 0;
        end
        c_dcnt++;
      end
      ready_and_i = 1'b0;
      if (v_o) begin
        if (!c_seen) begin
          c_seen = 1; c_scnt = 0;
          c_cur.w = w_o; c_cur.a = addr_o; c_cur.d = data_o; c_cur.m = wmask_o;
          c_cur.seen = cyc; c_cur.acc = -1;
        end else if (c_cur.w !== w_o || c_cur.a !== addr_o || c_cur.d !== data_o || c_cur.m !== wmask_o) begin
          c_unstable++;
        end
        if (c_scnt >= cfg_stall) begin
          ready_and_i = 1'b1;
          c_cur.acc   = cyc;
          log_q.push_back(c_cur);
          c_seen = 0; c_pend = 1; c_dcnt = 0; c_pend_w = c_cur.w; c_pend_a = c_cur.a;
          if (c_cur.w) cmem[c_cur.a] = merge(cmem_rd(c_cur.a), c_cur.d, c_cur.m);
          if (cfg_delay == 0) begin
            v_i    = 1'b1;
            data_i = c_cur.w ? DW'($urandom) : cmem_rd(c_cur.a);
          end
        end
        c_scnt++;
      end
    end
  end

  int hs_aw, hs_w, hs_ar;
  bit issue_to, b_to, r_to;
  int b_cyc, r_cyc, r_unst, r_high;
  logic [1:0]    b_resp, r_resp;
  logic [DW-1:0] r_data;

  // Presents AW/W/AR; w_lead > 0 puts W that many cycles ahead of AW, < 0 the reverse.
  task automatic axi_issue(input bit do_wr, input bit do_rd, input logic [AW-1:0] wa,
                           input logic [DW-1:0] wd, input logic [SW-1:0] ws,
                           input logic [AW-1:0] ra, input int w_lead);
    bit aw_d, w_d, ar_d;
    int k, aw_start, w_start;
    aw_d = !do_wr; w_d = !do_wr; ar_d = !do_rd; k = 0; issue_to = 0;
    aw_start = (w_lead > 0) ? w_lead : 0;
    w_start  = (w_lead < 0) ? -w_lead : 0;
    while (!(aw_d && w_d && ar_d)) begin
      @(negedge clk);
      if (k >= 200) begin issue_to = 1; break; end
      s_axil_awaddr_i = wa; s_axil_wdata_i = wd; s_axil_wstrb_i = ws; s_axil_araddr_i = ra;
      s_axil_awprot_i = 3'($urandom); s_axil_arprot_i = 3'($urandom);
      s_axil_awvalid_i = !aw_d && k >= aw_start;
      s_axil_wvalid_i  = !w_d && k >= w_start;
      s_axil_arvalid_i = !ar_d;
      if (s_axil_awvalid_i && s_axil_awready_o) begin aw_d = 1; hs_aw = cyc; end
      if (s_axil_wvalid_i && s_axil_wready_o) begin w_d = 1; hs_w = cyc; end
      if (s_axil_arvalid_i && s_axil_arready_o) begin ar_d = 1; hs_ar = cyc; end
      k++;
    end
    @(negedge clk);
    s_axil_awvalid_i = 0; s_axil_wvalid_i = 0; s_axil_arvalid_i = 0;
  endtask

  task automatic axi_wait_b(input int stall);
    int n;
    n = 0; b_cyc = -1; b_to = 1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (s_axil_bvalid_o) begin
        if (b_cyc < 0) begin b_cyc = cyc; b_resp = s_axil_bresp_o; end
        if (n >= stall) begin
          s_axil_bready_i = 1; b_to = 0;
          @(negedge clk);
          s_axil_bready_i = 0;
          break;
        end
        n++;
      end
    end
  endtask

  task automatic axi_wait_r(input int stall);
    int n;
    n = 0; r_cyc = -1; r_to = 1; r_unst = 0; r_high = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (s_axil_rvalid_o) begin
        r_high++;
        if (r_cyc < 0) begin r_cyc = cyc; r_data = s_axil_rdata_o; r_resp = s_axil_rresp_o; end
        else if (s_axil_rdata_o !== r_data) r_unst++;
        if (n >= stall) begin
          s_axil_rready_i = 1; r_to = 0;
          @(negedge clk);
          s_axil_rready_i = 0;
          break;
        end
        n++;
      end
    end
  endtask

  task automatic reset_dut();
    @(negedge clk); reset_i = 1;
    repeat (3) @(negedge clk);
    reset_i = 0;
  endtask

  task automatic test_reset();
    reset_i = 1;
    repeat (3) @(negedge clk);
    checks++; if (s_axil_awready_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_awready got %b want 0", s_axil_awready_o); end
    checks++; if (s_axil_wready_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_wready got %b want 0", s_axil_wready_o); end
    checks++; if (s_axil_arready_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_arready got %b want 0", s_axil_arready_o); end
    checks++; if ({v_o, ready_and_o, s_axil_bvalid_o, s_axil_rvalid_o} !== 4'b0) begin errors++; $display("[TB] FAIL rst_valids got %b want 0000", {v_o, ready_and_o, s_axil_bvalid_o, s_axil_rvalid_o}); end
    checks++; if ({addr_o, data_o, wmask_o, w_o} !== '0) begin errors++; $display("[TB] FAIL rst_req_fields got %h want 0", {addr_o, data_o, wmask_o, w_o}); end
    checks++; if (s_axil_rdata_o !== '0) begin errors++; $display("[TB] FAIL rst_rdata got %h want 0", s_axil_rdata_o); end
    reset_i = 0;
    @(negedge clk);
    checks++; if ({s_axil_awready_o, s_axil_wready_o, s_axil_arready_o} !== 3'b111) begin errors++; $display("[TB] FAIL post_rst_ready got %b want 111", {s_axil_awready_o, s_axil_wready_o, s_axil_arready_o}); end
  endtask

  task automatic test_write_same_cycle();
    int n0;
    cfg_stall = 0; cfg_delay = 0; n0 = log_q.size();
    axi_issue(1, 0, 32'h10, 32'hDEADBEEF, 4'hF, '0, 0);
    axi_wait_b(0);
    checks++; if (issue_to || b_to) begin errors++; $display("[TB] FAIL wr1_timeout got issue=%0b b=%0b want 0", issue_to, b_to); end
    checks++; if (hs_aw !== hs_w) begin errors++; $display("[TB] FAIL wr1_same_hs got aw=%0d w=%0d want equal", hs_aw, hs_w); end
    checks++; if (log_q.size() !== n0 + 1) begin errors++; $display("[TB] FAIL wr1_req_count got %0d want %0d", log_q.size(), n0 + 1); end
    else begin
      checks++; if ({log_q[n0].w, log_q[n0].a, log_q[n0].d, log_q[n0].m} !== {1'b1, 32'h10, 32'hDEADBEEF, 4'hF}) begin errors++; $display("[TB] FAIL wr1_fields got w=%b a=%h d=%h m=%h want 1 10 deadbeef f", log_q[n0].w, log_q[n0].a, log_q[n0].d, log_q[n0].m); end
      checks++; if (log_q[n0].seen - hs_aw !== 2) begin errors++; $display("[TB] FAIL wr1_vo_latency got %0d want 2", log_q[n0].seen - hs_aw); end
    end
    checks++; if (b_cyc - hs_aw !== 4) begin errors++; $display("[TB] FAIL wr1_b_latency got %0d want 4", b_cyc - hs_aw); end
    checks++; if (b_resp !== 2'b00) begin errors++; $display("[TB] FAIL wr1_bresp got %b want 00", b_resp); end
  endtask

  task automatic test_w_before_aw();
    int n0;
    logic [DW-1:0] d;
    d = $urandom; n0 = log_q.size();
    axi_issue(1, 0, 32'h20, d, 4'h3, '0, 3);
    axi_wait_b(0);
    checks++; if (hs_aw - hs_w !== 3) begin errors++; $display("[TB] FAIL wlead_order got %0d want 3", hs_aw - hs_w); end
    checks++; if (log_q.size() !== n0 + 1) begin errors++; $display("[TB] FAIL wlead_req_count got %0d want %0d", log_q.size(), n0 + 1); end
    else begin
      checks++; if (log_q[n0].seen - hs_aw !== 2) begin errors++; $display("[TB] FAIL wlead_vo_after_aw got %0d want 2", log_q[n0].seen - hs_aw); end
      checks++; if ({log_q[n0].w, log_q[n0].a, log_q[n0].d, log_q[n0].m} !== {1'b1, 32'h20, d, 4'h3}) begin errors++; $display("[TB] FAIL wlead_fields got a=%h d=%h m=%h want 20 %h 3", log_q[n0].a, log_q[n0].d, log_q[n0].m, d); end
    end
    checks++; if (b_to || b_resp !== 2'b00) begin errors++; $display("[TB] FAIL wlead_bresp got to=%0b resp=%b want 0 00", b_to, b_resp); end
  endtask

  task automatic test_read_delayed();
    int n0;
    cmem[32'h30] = 32'h12345678; cfg_delay = 5; n0 = log_q.size();
    axi_issue(0, 1, '0, '0, '0, 32'h30, 0);
    axi_wait_r(2);
    cfg_delay = 0;
    checks++; if (r_to || r_data !== 32'h12345678) begin errors++; $display("[TB] FAIL rd_data got to=%0b %h want 12345678", r_to, r_data); end
    checks++; if (r_unst !== 0 || r_high !== 3) begin errors++; $display("[TB] FAIL rd_hold got unstable=%0d high=%0d want 0 3", r_unst, r_high); end
    checks++; if (r_resp !== 2'b00) begin errors++; $display("[TB] FAIL rd_rresp got %b want 00", r_resp); end
    checks++; if (log_q.size() !== n0 + 1) begin errors++; $display("[TB] FAIL rd_req_count got %0d want %0d", log_q.size(), n0 + 1); end
    else begin
      checks++; if ({log_q[n0].w, log_q[n0].a} !== {1'b0, 32'h30}) begin errors++; $display("[TB] FAIL rd_fields got w=%b a=%h want 0 30", log_q[n0].w, log_q[n0].a); end
      checks++; if (r_cyc - log_q[n0].acc !== 7) begin errors++; $display("[TB] FAIL rd_latency got %0d want 7", r_cyc - log_q[n0].acc); end
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    logic [DW-1:0] rd_val;
    reset_dut();
    cfg_stall = 0; cfg_delay = 0; n0 = log_q.size();
    for (int rnd = 0; rnd < 2; rnd++) begin
      rd_val = $urandom;
      cmem[32'h44] = rd_val;
      axi_issue(1, 1, 32'h40, DW'($urandom), 4'hF, 32'h44, 0);
      checks++; if (hs_aw !== hs_ar || hs_w !== hs_ar) begin errors++; $display("[TB] FAIL b2b_same_hs got aw=%0d w=%0d ar=%0d want equal", hs_aw, hs_w, hs_ar); end
      axi_wait_b(0);
      axi_wait_r(0);
      checks++; if (b_to || r_to || r_data !== rd_val) begin errors++; $display("[TB] FAIL b2b_resp got bto=%0b rto=%0b rdata=%h want 0 0 %h", b_to, r_to, r_data, rd_val); end
    end
    checks++; if (log_q.size() !== n0 + 4) begin errors++; $display("[TB] FAIL b2b_req_count got %0d want %0d", log_q.size(), n0 + 4); end
    else begin
      checks++; if ({log_q[n0].w, log_q[n0+1].w, log_q[n0+2].w, log_q[n0+3].w} !== 4'b1010) begin errors++; $display("[TB] FAIL b2b_order got %b%b%b%b want 1010", log_q[n0].w, log_q[n0+1].w, log_q[n0+2].w, log_q[n0+3].w); end
      checks++; if (log_q[n0].a !== 32'h40 || log_q[n0+1].a !== 32'h44) begin errors++; $display("[TB] FAIL b2b_addr got %h %h want 40 44", log_q[n0].a, log_q[n0+1].a); end
    end
  endtask

  task automatic test_backpressure();
    int n0, u0;
    logic [DW-1:0] d;
    logic [SW-1:0] m;
    d = $urandom; m = SW'($urandom_range(1, 15));
    cfg_stall = 4; n0 = log_q.size(); u0 = c_unstable;
    axi_issue(1, 0, 32'h50, d, m, '0, 0);
    axi_wait_b(0);
    repeat (3) @(negedge clk);
    cfg_stall = 0;
    checks++; if (c_unstable - u0 !== 0) begin errors++; $display("[TB] FAIL bp_stable got %0d changes want 0", c_unstable - u0); end
    checks++; if (log_q.size() !== n0 + 1) begin errors++; $display("[TB] FAIL bp_req_count got %0d want %0d", log_q.size(), n0 + 1); end
    else begin
      checks++; if (log_q[n0].acc - log_q[n0].seen !== 4) begin errors++; $display("[TB] FAIL bp_stall got %0d want 4", log_q[n0].acc - log_q[n0].seen); end
      checks++; if ({log_q[n0].a, log_q[n0].d, log_q[n0].m} !== {32'h50, d, m}) begin errors++; $display("[TB] FAIL bp_fields got a=%h d=%h m=%h want 50 %h %h", log_q[n0].a, log_q[n0].d, log_q[n0].m, d, m); end
    end
    checks++; if (b_to) begin errors++; $display("[TB] FAIL bp_bresp got timeout want response"); end
  endtask

  task automatic test_reset_mid();
    int n0, k, rv;
    cfg_delay = 50; n0 = log_q.size(); k = 0;
    axi_issue(0, 1, '0, '0, '0, 32'h60, 0);
    while (log_q.size() == n0 && k < 50) begin @(negedge clk); k++; end
    checks++; if (log_q.size() !== n0 + 1) begin errors++; $display("[TB] FAIL rmid_req got %0d want %0d", log_q.size(), n0 + 1); end
    repeat (2) @(negedge clk);
    reset_i = 1;
    #1;
    checks++; if ({s_axil_awready_o, s_axil_wready_o, s_axil_arready_o, ready_and_o} !== 4'b0) begin errors++; $display("[TB] FAIL rmid_readys got %b want 0000", {s_axil_awready_o, s_axil_wready_o, s_axil_arready_o, ready_and_o}); end
    checks++; if ({v_o, s_axil_bvalid_o, s_axil_rvalid_o} !== 3'b0) begin errors++; $display("[TB] FAIL rmid_valids got %b want 000", {v_o, s_axil_bvalid_o, s_axil_rvalid_o}); end
    repeat (3) @(negedge clk);
    reset_i = 0; cfg_delay = 0; rv = 0;
    repeat (10) begin @(negedge clk); if (s_axil_rvalid_o || s_axil_bvalid_o) rv++; end
    checks++; if (rv !== 0) begin errors++; $display("[TB] FAIL rmid_no_resp got %0d valid cycles want 0", rv); end
    n0 = log_q.size();
    axi_issue(1, 0, 32'h70, 32'hA5A5_0F0F, 4'hF, '0, 0);
    axi_wait_b(0);
    checks++; if (b_to || b_resp !== 2'b00 || log_q.size() !== n0 + 1) begin errors++; $display("[TB] FAIL rmid_fresh_write got to=%0b resp=%b reqs=%0d want 0 00 %0d", b_to, b_resp, log_q.size(), n0 + 1); end
    else begin
      checks++; if (log_q[n0].a !== 32'h70 || log_q[n0].d !== 32'hA5A5_0F0F) begin errors++; $display("[TB] FAIL rmid_fresh_fields got a=%h d=%h want 70 a5a50f0f", log_q[n0].a, log_q[n0].d); end
    end
  endtask

  task automatic test_random();
    int n0;
    bit wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d, exp_d;
    logic [SW-1:0] s;
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom);
      a  = 32'h100 + AW'($urandom_range(0, 7) * 4);
      d  = $urandom;
      s  = SW'($urandom);
      cfg_stall = $urandom_range(0, 3);
      cfg_delay = $urandom_range(0, 3);
      n0 = log_q.size();
      if (wr) begin
        ref_mem[a] = merge(ref_rd(a), d, s);
        axi_issue(1, 0, a, d, s, '0, $urandom_range(0, 4) - 2);
        axi_wait_b($urandom_range(0, 2));
        checks++; if (b_to || b_resp !== 2'b00) begin errors++; $display("[TB] FAIL rand_b[%0d] got to=%0b resp=%b want 0 00", t, b_to, b_resp); end
      end else begin
        exp_d = ref_rd(a);
        axi_issue(0, 1, '0, '0, '0, a, 0);
        axi_wait_r($urandom_range(0, 2));
        checks++; if (r_to || r_resp !== 2'b00 || r_data !== exp_d) begin errors++; $display("[TB] FAIL rand_r[%0d] got to=%0b resp=%b data=%h want 0 00 %h", t, r_to, r_resp, r_data, exp_d); end
      end
      checks++; if (log_q.size() !== n0 + 1) begin errors++; $display("[TB] FAIL rand_req_count[%0d] got %0d want %0d", t, log_q.size(), n0 + 1); end
      else if (wr) begin
        checks++; if ({log_q[n0].w, log_q[n0].a, log_q[n0].d, log_q[n0].m} !== {1'b1, a, d, s}) begin errors++; $display("[TB] FAIL rand_wreq[%0d] got w=%b a=%h d=%h m=%h want 1 %h %h %h", t, log_q[n0].w, log_q[n0].a, log_q[n0].d, log_q[n0].m, a, d, s); end
      end else begin
        checks++; if ({log_q[n0].w, log_q[n0].a} !== {1'b0, a}) begin errors++; $display("[TB] FAIL rand_rreq[%0d] got w=%b a=%h want 0 %h", t, log_q[n0].w, log_q[n0].a, a); end
      end
    end
    cfg_stall = 0; cfg_delay = 0;
  endtask

  // Sequence the scenarios and report.
  initial begin
    reset_i = 1;
    s_axil_awaddr_i = '0; s_axil_awprot_i = '0; s_axil_awvalid_i = 0;
    s_axil_wdata_i = '0; s_axil_wstrb_i = '0; s_axil_wvalid_i = 0;
    s_axil_bready_i = 0;
    s_axil_araddr_i = '0; s_axil_arprot_i = '0; s_axil_arvalid_i = 0;
    s_axil_rready_i = 0;
    ready_and_i = 0; v_i = 0; data_i = '0;
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_read_delayed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
